branch_predictor_gshare: RTL and testbench

- Parametrised successor to the pipeline's fixed branch prediction unit.
- Fetch-stage direction predictor: a PHT of saturating counters, indexed by PC optionally XORed with global history, plus a tagged BTB for targets.
- Keeps an internal decode-stage shadow of each prediction, so decode-stage resolution updates exactly the entry used at fetch.
- Drives mispredict and the corrected PC to the PC-select mux and the IF/ID flush logic.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/bp_pht.sv | 34 +++
 rtl/branch_predictor_gshare.sv | 133 +++++++++++++
 tb/tb_branch_predictor_gshare.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared helpers for the gshare branch predictor: counter constants, PHT indexing, counter stepping.
package bp_pkg;

  localparam int unsigned PC_W_DEF    = 8;
  localparam int unsigned INDEX_W_DEF = 4;
  localparam int unsigned CTR_W_DEF   = 2;
  localparam int unsigned GHR_W_DEF   = 4;
  localparam int unsigned PERF_W_DEF  = 16;

  // Weakly not-taken starting value for a ctr_w-bit counter.
  function automatic int unsigned ctr_init(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 32'd1)) - 32'd1;
  endfunction

  // Strongly taken saturation value for a ctr_w-bit counter.
  function automatic int unsigned ctr_max(input int unsigned ctr_w);
    return (32'd1 << ctr_w) - 32'd1;
  endfunction

  // PHT index: low pc bits, optionally XORed with the zero-extended history.
  function automatic int unsigned pht_index(input int unsigned pc, input int unsigned ghr,
                                            input bit gshare, input int unsigned index_w);
    int unsigned mask;
    mask = (32'd1 << index_w) - 32'd1;
    return gshare ? ((pc ^ ghr) & mask) : (pc & mask);
  endfunction

  // One saturating step toward the resolved direction.
  function automatic int unsigned sat_step(input int unsigned ctr, input bit taken,
                                           input int unsigned ctr_w);
    if (taken) return (ctr >= ctr_max(ctr_w)) ? ctr : ctr + 32'd1;
    else       return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: saturating counters, one async read port, one read-modify-write port.
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned CTR_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [CTR_W-1:0]   rd_ctr,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic               wr_taken
);

  localparam int unsigned DEPTH = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

  logic [CTR_W-1:0] ctr_q [DEPTH];

  // Read returns the pre-edge value, so a same-cycle write is not visible.
  assign rd_ctr = ctr_q[rd_idx];

  // Counter storage: reset to weakly not-taken, train toward the resolved outcome.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ctr_q[INDEX_W'(i)] <= CTR_INIT;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= CTR_W'(sat_step(32'(ctr_q[wr_idx]), wr_taken, CTR_W));
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Fetch-stage gshare/bimodal direction predictor with tagged BTB and decode-stage resolution.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned GHR_W   = 4,
  parameter bit          GSHARE  = 1'b1,
  parameter int unsigned PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  output logic              mispredict,
  output logic [PC_W-1:0]   corrected_pc,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int unsigned DEPTH = 1 << INDEX_W;
  localparam int unsigned TAG_W = PC_W - INDEX_W;

  logic [GHR_W-1:0]   ghr_q;
  logic [DEPTH-1:0]   btb_valid_q;
  logic [TAG_W-1:0]   btb_tag_q [DEPTH];
  logic [PC_W-1:0]    btb_tgt_q [DEPTH];

  logic [PC_W-1:0]    pc_d_q;
  logic [INDEX_W-1:0] pht_idx_d_q;
  logic               pred_taken_d_q;
  logic [PC_W-1:0]    pred_target_d_q;

  logic [INDEX_W-1:0] btb_idx;
  logic [INDEX_W-1:0] pht_idx;
  logic [INDEX_W-1:0] upd_btb_idx;
  logic [TAG_W-1:0]   pc_tag;
  logic [CTR_W-1:0]   pht_ctr;
  logic               btb_hit;
  logic               upd_act;

  // Fetch-side lookup.
  assign btb_idx     = pc[INDEX_W-1:0];
  assign pc_tag      = pc[PC_W-1:INDEX_W];
  assign pht_idx     = INDEX_W'(pht_index(32'(pc), 32'(ghr_q), GSHARE, INDEX_W));
  assign btb_hit     = btb_valid_q[btb_idx] && (btb_tag_q[btb_idx] == pc_tag);
  assign pred_taken  = btb_hit && pht_ctr[CTR_W-1];
  assign pred_target = btb_tgt_q[btb_idx];

  // Decode-side resolution against the shadowed prediction.
  assign upd_act      = upd_valid && enable;
  assign upd_btb_idx  = pc_d_q[INDEX_W-1:0];
  assign mispredict   = upd_act && ((pred_taken_d_q != upd_taken) ||
                                    (upd_taken && (pred_target_d_q != upd_target)));
  assign corrected_pc = upd_taken ? upd_target : pc_d_q + PC_W'(1);

  bp_pht #(
    .INDEX_W (INDEX_W),
    .CTR_W   (CTR_W)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pht_idx),
    .rd_ctr   (pht_ctr),
    .wr_en    (upd_act),
    .wr_idx   (pht_idx_d_q),
    .wr_taken (upd_taken)
  );

  // BTB allocation on taken outcomes only; not-taken never invalidates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        btb_tag_q[INDEX_W'(i)] <= '0;
        btb_tgt_q[INDEX_W'(i)] <= '0;
      end
    end else if (upd_act && upd_taken) begin
      btb_valid_q[upd_btb_idx] <= 1'b1;
      btb_tag_q[upd_btb_idx]   <= pc_d_q[PC_W-1:INDEX_W];
      btb_tgt_q[upd_btb_idx]   <= upd_target;
    end
  end

  // Non-speculative global history, shifted only on resolution.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q <= '0;
    end else if (upd_act) begin
      ghr_q <= GHR_W'({ghr_q, upd_taken});
    end
  end

  // Decode shadow of the fetch prediction: clear on flush/redirect, load when advancing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_d_q          <= '0;
      pht_idx_d_q     <= '0;
      pred_taken_d_q  <= 1'b0;
      pred_target_d_q <= '0;
    end else if (flush || mispredict) begin
      pc_d_q          <= '0;
      pht_idx_d_q     <= '0;
      pred_taken_d_q  <= 1'b0;
      pred_target_d_q <= '0;
    end else if (enable && !stall) begin
      pc_d_q          <= pc;
      pht_idx_d_q     <= pht_idx;
      pred_taken_d_q  <= pred_taken;
      pred_target_d_q <= pred_target;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (upd_act) begin
      if (perf_branches != '1) perf_branches <= perf_branches + PERF_W'(1);
      if (mispredict && (perf_mispredicts != '1)) perf_mispredicts <= perf_mispredicts + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench: bimodal and gshare instances driven in lockstep, checked against an array-based model.
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, stall, flush, upd_valid, upd_taken;
  logic [7:0]  pc, upd_target;

  logic        pt0, pt1, mp0, mp1;
  logic [7:0]  ptg0, ptg1, cp0, cp1;
  logic [15:0] pb0, pb1, pm0, pm1;

  int tests = 0;
  int fails = 0;

  // Model state, index 0 = bimodal instance, 1 = gshare instance.
  int m_pht [2][16];
  int m_bv  [2][16];
  int m_tag [2][16];
  int m_tgt [2][16];
  int m_ghr [2];
  int m_spc [2], m_sidx [2], m_stk [2], m_stgt [2];
  int m_pb  [2], m_pm [2];
  int e_idx [2], e_pt [2], e_ptgt [2], e_mis [2], e_cp [2];
  int c_p, c_uv, c_ut, c_tgt, c_st, c_fl, c_en;

  always #5 clk = ~clk;

  branch_predictor_gshare #(.GSHARE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .stall(stall), .flush(flush), .pc(pc),
    .pred_taken(pt0), .pred_target(ptg0), .upd_valid(upd_valid), .upd_taken(upd_taken),
    .upd_target(upd_target), .mispredict(mp0), .corrected_pc(cp0),
    .perf_branches(pb0), .perf_mispredicts(pm0)
  );

  branch_predictor_gshare #(.GSHARE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .stall(stall), .flush(flush), .pc(pc),
    .pred_taken(pt1), .pred_target(ptg1), .upd_valid(upd_valid), .upd_taken(upd_taken),
    .upd_target(upd_target), .mispredict(mp1), .corrected_pc(cp1),
    .perf_branches(pb1), .perf_mispredicts(pm1)
  );

  function automatic int o_pt(input int g);  return (g == 0) ? int'(pt0)  : int'(pt1);  endfunction
  function automatic int o_ptg(input int g); return (g == 0) ? int'(ptg0) : int'(ptg1); endfunction
  function automatic int o_mp(input int g);  return (g == 0) ? int'(mp0)  : int'(mp1);  endfunction
  function automatic int o_cp(input int g);  return (g == 0) ? int'(cp0)  : int'(cp1);  endfunction
  function automatic int o_pb(input int g);  return (g == 0) ? int'(pb0)  : int'(pb1);  endfunction
  function automatic int o_pm(input int g);  return (g == 0) ? int'(pm0)  : int'(pm1);  endfunction

  task automatic chk(input string nm, input int g, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t: got 0x%0h expected 0x%0h", nm, g, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 16; i++) begin
        m_pht[g][i] = 1; m_bv[g][i] = 0; m_tag[g][i] = 0; m_tgt[g][i] = 0;
      end
      m_ghr[g] = 0; m_spc[g] = 0; m_sidx[g] = 0; m_stk[g] = 0; m_stgt[g] = 0;
      m_pb[g] = 0; m_pm[g] = 0;
    end
  endtask

  // Apply inputs, let combinational paths settle, compare every output to the model.
  task automatic drive(input int p, input int uv, input int ut, input int tgt,
                       input int st, input int fl, input int en);
    pc = 8'(p); upd_valid = (uv != 0); upd_taken = (ut != 0); upd_target = 8'(tgt);
    stall = (st != 0); flush = (fl != 0); enable = (en != 0);
    c_p = p & 255; c_uv = uv; c_ut = ut; c_tgt = tgt & 255; c_st = st; c_fl = fl; c_en = en;
    #1;
    for (int g = 0; g < 2; g++) begin
      int bidx;
      int hit;
      bidx = c_p & 15;
      e_idx[g] = (g == 1) ? ((c_p ^ m_ghr[g]) & 15) : (c_p & 15);
      hit = (m_bv[g][bidx] != 0 && m_tag[g][bidx] == (c_p >> 4)) ? 1 : 0;
      e_pt[g] = (hit != 0 && m_pht[g][e_idx[g]] >= 2) ? 1 : 0;
      e_ptgt[g] = m_tgt[g][bidx];
      e_mis[g] = ((c_uv != 0 && c_en != 0) &&
                  (m_stk[g] != c_ut || (c_ut != 0 && m_stgt[g] != c_tgt))) ? 1 : 0;
      e_cp[g] = (c_ut != 0) ? c_tgt : ((m_spc[g] + 1) & 255);
      chk("pred_taken", g, o_pt(g), e_pt[g]);
      if (e_pt[g] != 0) chk("pred_target", g, o_ptg(g), e_ptgt[g]);
      chk("mispredict", g, o_mp(g), e_mis[g]);
      if (e_mis[g] != 0) chk("corrected_pc", g, o_cp(g), e_cp[g]);
      chk("perf_branches", g, o_pb(g), m_pb[g]);
      chk("perf_mispredicts", g, o_pm(g), m_pm[g]);
    end
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        if (c_uv != 0 && c_en != 0) begin
          int c;
          c = m_pht[g][m_sidx[g]];
          m_pht[g][m_sidx[g]] = (c_ut != 0) ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
          if (c_ut != 0) begin
            m_bv[g][m_spc[g] & 15]  = 1;
            m_tag[g][m_spc[g] & 15] = m_spc[g] >> 4;
            m_tgt[g][m_spc[g] & 15] = c_tgt;
          end
          m_ghr[g] = ((m_ghr[g] << 1) | c_ut) & 15;
          if (m_pb[g] < 65535) m_pb[g]++;
          if (e_mis[g] != 0 && m_pm[g] < 65535) m_pm[g]++;
        end
        if (c_fl != 0 || e_mis[g] != 0) begin
          m_spc[g] = 0; m_sidx[g] = 0; m_stk[g] = 0; m_stgt[g] = 0;
        end else if (c_en != 0 && c_st == 0) begin
          m_spc[g] = c_p; m_sidx[g] = e_idx[g]; m_stk[g] = e_pt[g]; m_stgt[g] = e_ptgt[g];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Fetch at 0x10, then resolve in the following cycle while fetching filler 0x33.
  task automatic branch(input int ut);
    drive(8'h10, 0, 0, 0, 0, 0, 1); tick();
    drive(8'h33, 1, ut, 8'h20, 0, 0, 1); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; enable = 1'b1; stall = 1'b0; flush = 1'b0;
    pc = '0; upd_valid = 1'b0; upd_taken = 1'b0; upd_target = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Reset state and first cold branch.
    drive(8'h10, 0, 0, 0, 0, 0, 1);
    chk("lit_reset_pred", 0, o_pt(0), 0);
    chk("lit_reset_perf", 1, o_pb(1), 0);
    tick();
    drive(8'h33, 1, 1, 8'h20, 0, 0, 1);
    chk("lit_cold_mis", 0, o_mp(0), 1);
    chk("lit_cold_cpc", 0, o_cp(0), 8'h20);
    tick();

    // Second fetch of the same branch is now predicted taken.
    drive(8'h10, 0, 0, 0, 0, 0, 1);
    chk("lit_perf_mis1", 0, o_pm(0), 1);
    chk("lit_trained_pred", 0, o_pt(0), 1);
    chk("lit_trained_tgt", 0, o_ptg(0), 8'h20);
    tick();
    drive(8'h33, 1, 1, 8'h20, 0, 0, 1);
    chk("lit_trained_mis", 0, o_mp(0), 0);
    tick();

    // Saturate, then walk back down with not-taken outcomes.
    for (int i = 0; i < 3; i++) branch(1);
    drive(8'h10, 0, 0, 0, 0, 0, 1);
    chk("lit_sat_pred", 0, o_pt(0), 1);
    tick();
    drive(8'h33, 1, 0, 8'h20, 0, 0, 1);
    chk("lit_nt1_mis", 0, o_mp(0), 1);
    chk("lit_nt1_cpc", 0, o_cp(0), 8'h11);
    tick();
    drive(8'h10, 0, 0, 0, 0, 0, 1);
    chk("lit_ctr2_pred", 0, o_pt(0), 1);
    tick();
    drive(8'h33, 1, 0, 8'h20, 0, 0, 1); tick();
    drive(8'h10, 0, 0, 0, 0, 0, 1);
    chk("lit_ctr1_pred", 0, o_pt(0), 0);
    tick();
    drive(8'h33, 1, 0, 8'h20, 0, 0, 1);
    chk("lit_ctr1_mis", 0, o_mp(0), 0);
    tick();

    // Alternating pattern learned by the history-indexed instance.
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      branch(1);
      branch(0);
    end
    drive(8'h10, 0, 0, 0, 0, 0, 1);
    chk("lit_alt_branches", 1, o_pb(1), 32);
    chk("lit_alt_mispredicts", 1, o_pm(1), 3);
    chk("lit_alt_pred", 1, o_pt(1), 1);
    tick();

    // Stall holds the shadow across unrelated fetches.
    for (int i = 0; i < 3; i++) begin
      drive(8'h44, 0, 0, 0, 1, 0, 1); tick();
    end
    drive(8'h33, 1, 1, 8'h20, 0, 0, 1);
    chk("lit_stall_mis", 1, o_mp(1), 0);
    tick();

    // Flush discards a taken prediction.
    drive(8'h10, 0, 0, 0, 0, 0, 1);
    chk("lit_preflush_pred", 0, o_pt(0), 1);
    tick();
    drive(8'h44, 0, 0, 0, 0, 1, 1); tick();
    drive(8'h33, 1, 1, 8'h20, 0, 0, 1);
    chk("lit_flush_mis", 0, o_mp(0), 1);
    chk("lit_flush_cpc", 0, o_cp(0), 8'h20);
    tick();

    // Asynchronous reset in the middle of an update cycle.
    drive(8'h10, 0, 0, 0, 0, 0, 1); tick();
    drive(8'h33, 1, 1, 8'h20, 0, 0, 1);
    rst = 1'b0;
    #1;
    chk("lit_midrst_perf", 0, o_pb(0), 0);
    chk("lit_midrst_perfm", 1, o_pm(1), 0);
    chk("lit_midrst_mis", 0, o_mp(0), 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(8'h10, 0, 0, 0, 0, 0, 1);
    chk("lit_postrst_pred0", 0, o_pt(0), 0);
    chk("lit_postrst_pred1", 1, o_pt(1), 0);
    tick();

    // enable=0 gates resolution, training and counting.
    drive(8'h33, 1, 1, 8'h20, 0, 0, 0);
    chk("lit_dis_mis", 0, o_mp(0), 0);
    tick();
    drive(8'h10, 1, 1, 8'h20, 0, 0, 0);
    chk("lit_dis_perf", 0, o_pb(0), 0);
    chk("lit_dis_pred", 0, o_pt(0), 0);
    tick();

    // Randomized traffic over a small PC/target set for frequent aliasing and hits.
    for (int n = 0; n < 800; n++) begin
      int p, t, r;
      r = int'($urandom_range(0, 4));
      case (r)
        0: p = 8'h10; 1: p = 8'h21; 2: p = 8'h32; 3: p = 8'h40;
        default: p = int'($urandom_range(0, 255));
      endcase
      r = int'($urandom_range(0, 2));
      t = (r == 0) ? 8'h20 : ((r == 1) ? 8'h55 : int'($urandom_range(0, 255)));
      drive(p, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), t,
            ($urandom_range(0, 4) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 0 : 1);
      tick();
      if ($urandom_range(0, 199) == 0) reset_dut();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
